// File: rtl/game_pkg.sv
// ============================================================================
// Module   : game_pkg
// Brief    : Shared state encoding, score width and popcount helper for the
//            space-shooter game sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package game_pkg;

  localparam int SCORE_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } game_state_t;

  function automatic logic [SCORE_W-1:0] popcount(input logic [31:0] bits);
    logic [SCORE_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {{(SCORE_W-1){1'b0}}, bits[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_slot_picker.sv
// ============================================================================
// Module   : rr_slot_picker
// Brief    : Combinational round-robin finder: first free slot searching from
//            pointer+1 upward, wrapping modulo SLOTS.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_slot_picker #(
  parameter int SLOTS = 10,
  parameter int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic [SLOTS-1:0] free,
  input  logic [IDX_W-1:0] pointer,
  output logic             found,
  output logic [SLOTS-1:0] grant,
  output logic [IDX_W-1:0] index
);

  localparam logic [IDX_W:0] c_slots = (IDX_W+1)'(SLOTS);

  logic [IDX_W:0] w_cand;

  always_comb begin
    found  = 1'b0;
    grant  = '0;
    index  = '0;
    w_cand = '0;
    // Offset SLOTS lands back on the pointer itself, so it is searched last.
    for (int k = 1; k <= SLOTS; k++) begin
      w_cand = {1'b0, pointer} + (IDX_W+1)'(k);
      if (w_cand >= c_slots) begin
        w_cand = w_cand - c_slots;
      end
      if (!found && free[w_cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        grant[w_cand[IDX_W-1:0]]  = 1'b1;
        index                     = w_cand[IDX_W-1:0];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
// Module   : game_sequencer
// Brief    : Frame-synchronous game controller: play-state FSM, lives, score,
//            round-robin asteroid spawning and ship visibility/motion gating.
//            Optional macro GAME_BONUS_LIFE_EN awards a life per 100 points.
// Revision : 1.0
// ============================================================================
`default_nettype none

module game_sequencer
  import game_pkg::*;
#(
  parameter int ASTEROID_COUNT = 10,
  parameter int LIVES          = 3,
  parameter int HIT_FRAMES     = 90,
  parameter int SPAWN_FRAMES   = 60,
  parameter int BLINK_FRAMES   = 8,
  parameter int SCORE_MAX      = 999
) (
  input  logic                          clk_pix,
  input  logic                          reset_n,
  input  logic                          frame,
  input  logic                          start,
  input  logic                          collision,
  input  logic [ASTEROID_COUNT-1:0]     asteroid_shot,
  input  logic [ASTEROID_COUNT-1:0]     asteroid_enabled,
  output logic [1:0]                    state,
  output logic [$clog2(LIVES+1)-1:0]    lives,
  output logic [SCORE_W-1:0]            score,
  output logic                          asteroid_rst,
  output logic [ASTEROID_COUNT-1:0]     spawn,
  output logic                          ship_visible,
  output logic                          ship_freeze
);

  localparam int c_lives_w = $clog2(LIVES+1);
  localparam int c_idx_w   = (ASTEROID_COUNT > 1) ? $clog2(ASTEROID_COUNT) : 1;
  localparam int c_hit_w   = $clog2(HIT_FRAMES+1);
  localparam int c_blink_w = $clog2(BLINK_FRAMES+1);
  localparam int c_spawn_w = $clog2(SPAWN_FRAMES+1);

  localparam logic [1:0] c_idle = 2'(IDLE);
  localparam logic [1:0] c_play = 2'(PLAY);
  localparam logic [1:0] c_hit  = 2'(HIT);
  localparam logic [1:0] c_over = 2'(OVER);

  localparam logic [c_lives_w-1:0] c_lives       = c_lives_w'(LIVES);
  localparam logic [c_lives_w-1:0] c_one_life    = c_lives_w'(1);
  localparam logic [c_hit_w-1:0]   c_hit_last    = c_hit_w'(HIT_FRAMES-1);
  localparam logic [c_blink_w-1:0] c_blink_last  = c_blink_w'(BLINK_FRAMES-1);
  localparam logic [c_spawn_w-1:0] c_spawn_last  = c_spawn_w'(SPAWN_FRAMES-1);
  localparam logic [SCORE_W:0]     c_score_max_w = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W-1:0]   c_score_max   = SCORE_W'(SCORE_MAX);

  logic                      r_start_q;
  logic [c_hit_w-1:0]        r_hit_cnt;
  logic [c_blink_w-1:0]      r_blink_cnt;
  logic [c_spawn_w-1:0]      r_spawn_cnt;
  logic [c_idx_w-1:0]        r_ptr;

  logic                      w_start_edge;
  logic [SCORE_W-1:0]        w_pop;
  logic [SCORE_W:0]          w_sum;
  logic [SCORE_W-1:0]        w_score_next;
  logic [c_lives_w-1:0]      w_lives_bonus;
  logic [c_lives_w-1:0]      w_lives_next;
  logic                      w_hit_now;
  logic                      w_to_over;
  logic                      w_found;
  logic [ASTEROID_COUNT-1:0] w_grant;
  logic [c_idx_w-1:0]        w_index;

  assign w_start_edge = start & ~r_start_q;
  assign w_pop        = popcount(32'(asteroid_shot));
  assign w_sum        = {1'b0, score} + {1'b0, w_pop};
  assign w_score_next = (w_sum > c_score_max_w) ? c_score_max : w_sum[SCORE_W-1:0];

`ifdef GAME_BONUS_LIFE_EN
  localparam logic [SCORE_W-1:0] c_hundred = SCORE_W'(100);
  logic w_bonus;
  // Several hundreds crossed in one frame still count as a single crossing.
  assign w_bonus       = (w_score_next / c_hundred) != (score / c_hundred);
  assign w_lives_bonus = (w_bonus && (lives < c_lives)) ? lives + c_one_life : lives;
`else
  assign w_lives_bonus = lives;
`endif

  // The bonus is applied before the collision so the score lands first.
  assign w_hit_now    = (state == c_play) && collision;
  assign w_lives_next = w_hit_now ? w_lives_bonus - c_one_life : w_lives_bonus;
  assign w_to_over    = w_hit_now && (w_lives_next == '0);

  rr_slot_picker #(
    .SLOTS (ASTEROID_COUNT),
    .IDX_W (c_idx_w)
  ) u_picker (
    .free    (~asteroid_enabled),
    .pointer (r_ptr),
    .found   (w_found),
    .grant   (w_grant),
    .index   (w_index)
  );

  always_ff @(posedge clk_pix or negedge reset_n) begin
    if (!reset_n) begin
      state        <= c_idle;
      lives        <= '0;
      score        <= '0;
      asteroid_rst <= 1'b0;
      spawn        <= '0;
      ship_visible <= 1'b1;
      ship_freeze  <= 1'b1;
      r_start_q    <= 1'b0;
      r_hit_cnt    <= '0;
      r_blink_cnt  <= '0;
      r_spawn_cnt  <= '0;
      r_ptr        <= '0;
    end else begin
      r_start_q    <= start;
      asteroid_rst <= 1'b0;
      spawn        <= '0;
      case (state)
        c_idle: begin
          if (w_start_edge) begin
            state        <= c_play;
            lives        <= c_lives;
            score        <= '0;
            r_spawn_cnt  <= '0;
            r_ptr        <= '0;
            asteroid_rst <= 1'b1;
            ship_visible <= 1'b1;
            ship_freeze  <= 1'b0;
          end
        end
        c_play, c_hit: begin
          if (frame) begin
            score <= w_score_next;
            lives <= w_lives_next;
            if (r_spawn_cnt == c_spawn_last) begin
              r_spawn_cnt <= '0;
              if (w_found && !w_to_over) begin
                spawn <= w_grant;
                r_ptr <= w_index;
              end
            end else begin
              r_spawn_cnt <= r_spawn_cnt + 1'b1;
            end
            if (state == c_play) begin
              if (w_to_over) begin
                state        <= c_over;
                ship_visible <= 1'b0;
                ship_freeze  <= 1'b1;
              end else if (w_hit_now) begin
                state       <= c_hit;
                r_hit_cnt   <= c_hit_last;
                r_blink_cnt <= '0;
              end
            end else if (r_hit_cnt == '0) begin
              state        <= c_play;
              ship_visible <= 1'b1;
            end else begin
              r_hit_cnt <= r_hit_cnt - 1'b1;
              if (r_blink_cnt == c_blink_last) begin
                r_blink_cnt  <= '0;
                ship_visible <= ~ship_visible;
              end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
              end
            end
          end
        end
        c_over: begin
          if (w_start_edge) begin
            state        <= c_idle;
            ship_visible <= 1'b1;
          end
        end
        default: state <= c_idle;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
// Module   : tb_game_sequencer
// Brief    : Self-checking bench for game_sequencer against a frame-level
//            behavioural model, directed scenarios plus random play.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_game_sequencer;

  localparam int N            = 10;
  localparam int LIVES        = 3;
  localparam int HIT_FRAMES   = 90;
  localparam int SPAWN_FRAMES = 60;
  localparam int BLINK_FRAMES = 8;
  localparam int SCORE_MAX    = 999;

  logic         clk_pix = 1'b0;
  logic         reset_n = 1'b0;
  logic         frame = 1'b0;
  logic         start = 1'b0;
  logic         collision = 1'b0;
  logic [N-1:0] asteroid_shot = '0;
  logic [N-1:0] asteroid_enabled = '1;
  logic [1:0]   state;
  logic [1:0]   lives;
  logic [9:0]   score;
  logic         asteroid_rst;
  logic [N-1:0] spawn;
  logic         ship_visible;
  logic         ship_freeze;

  always #20 clk_pix = ~clk_pix;

  game_sequencer #(
    .ASTEROID_COUNT (N),
    .LIVES          (LIVES),
    .HIT_FRAMES     (HIT_FRAMES),
    .SPAWN_FRAMES   (SPAWN_FRAMES),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SCORE_MAX      (SCORE_MAX)
  ) dut (
    .clk_pix          (clk_pix),
    .reset_n          (reset_n),
    .frame            (frame),
    .start            (start),
    .collision        (collision),
    .asteroid_shot    (asteroid_shot),
    .asteroid_enabled (asteroid_enabled),
    .state            (state),
    .lives            (lives),
    .score            (score),
    .asteroid_rst     (asteroid_rst),
    .spawn            (spawn),
    .ship_visible     (ship_visible),
    .ship_freeze      (ship_freeze)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: game state in spec terms (0=IDLE 1=PLAY 2=HIT 3=OVER)
  int           m_state, m_lives, m_score, m_frames, m_ptr, m_hit_el;
  bit           m_rst, m_vis, m_frz, m_prev_start;
  logic [N-1:0] m_spawn;
  logic [N-1:0] seen_spawn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_lives = 0; m_score = 0; m_frames = 0; m_ptr = 0; m_hit_el = 0;
    m_rst = 0; m_vis = 1; m_frz = 1; m_prev_start = 0; m_spawn = '0;
  endtask

  task automatic model_step();
    bit edge_s, to_over, got_slot;
    int old_s, new_s, slot;
    edge_s = start && !m_prev_start;
    m_prev_start = start;
    m_rst = 0;
    m_spawn = '0;
    case (m_state)
      0: if (edge_s) begin
        m_state = 1; m_lives = LIVES; m_score = 0; m_frames = 0; m_ptr = 0;
        m_rst = 1; m_vis = 1; m_frz = 0;
      end
      1, 2: if (frame) begin
        old_s = m_score;
        new_s = old_s + $countones(asteroid_shot);
        if (new_s > SCORE_MAX) new_s = SCORE_MAX;
        m_score = new_s;
`ifdef GAME_BONUS_LIFE_EN
        if ((new_s / 100) != (old_s / 100) && m_lives < LIVES) m_lives++;
`endif
        to_over = 0;
        if (m_state == 1 && collision) begin
          m_lives--;
          if (m_lives == 0) begin
            to_over = 1; m_state = 3; m_vis = 0; m_frz = 1;
          end else begin
            m_state = 2; m_hit_el = 0;
          end
        end else if (m_state == 2) begin
          if (m_hit_el == HIT_FRAMES - 1) begin
            m_state = 1; m_vis = 1;
          end else begin
            m_hit_el++;
            m_vis = ((m_hit_el / BLINK_FRAMES) % 2) == 0;
          end
        end
        m_frames++;
        if ((m_frames % SPAWN_FRAMES) == 0 && !to_over) begin
          got_slot = 0;
          for (int k = 1; k <= N; k++) begin
            slot = (m_ptr + k) % N;
            if (!got_slot && !asteroid_enabled[slot]) begin
              got_slot = 1;
              m_spawn[slot] = 1'b1;
              m_ptr = slot;
            end
          end
        end
      end
      default: if (edge_s) begin
        m_state = 0; m_vis = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"}, 32'(state), m_state);
    check({tag, ".lives"}, 32'(lives), m_lives);
    check({tag, ".score"}, 32'(score), m_score);
    check({tag, ".asteroid_rst"}, 32'(asteroid_rst), 32'(m_rst));
    check({tag, ".spawn"}, 32'(spawn), 32'(m_spawn));
    check({tag, ".ship_visible"}, 32'(ship_visible), 32'(m_vis));
    check({tag, ".ship_freeze"}, 32'(ship_freeze), 32'(m_frz));
  endtask

  task automatic cyc(input bit f, input bit s, input bit c,
                     input logic [N-1:0] shot, input logic [N-1:0] en);
    frame = f; start = s; collision = c;
    asteroid_shot = shot; asteroid_enabled = en;
    @(posedge clk_pix);
    model_step();
    #1;
    check_all("cyc");
    if (spawn != '0) seen_spawn = spawn;
  endtask

  task automatic frame_tick(input logic [N-1:0] shot, input bit c, input logic [N-1:0] en);
    cyc(1'b1, 1'b0, c, shot, en);
    cyc(1'b0, 1'b0, 1'b0, '0, en);
  endtask

  task automatic pulse_start();
    cyc(1'b0, 1'b1, 1'b0, '0, '1);
    cyc(1'b0, 1'b0, 1'b0, '0, '1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    frame = 1'b0; start = 1'b0; collision = 1'b0; asteroid_shot = '0;
    #2;
    model_reset();
    check_all("async_rst");
    repeat (2) @(posedge clk_pix);
    @(negedge clk_pix);
    reset_n = 1'b1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check_all("reset");
    @(negedge clk_pix);
    reset_n = 1'b1;
    repeat (4) frame_tick('1, 1'b0, '1);

    // Start: one-cycle asteroid clear, full lives, ship released
    cyc(1'b0, 1'b1, 1'b0, '0, '1);
    check("start_rst", 32'(asteroid_rst), 1);
    check("start_state", 32'(state), 1);
    check("start_lives", 32'(lives), 3);
    check("start_freeze", 32'(ship_freeze), 0);
    cyc(1'b0, 1'b0, 1'b0, '0, '1);
    check("start_rst_drop", 32'(asteroid_rst), 0);

    // Spawn arbitration
    seen_spawn = '0;
    repeat (SPAWN_FRAMES) frame_tick('0, 1'b0, 10'b1111110111);
    check("spawn_slot3", 32'(seen_spawn), 32'(10'b0000001000));
    seen_spawn = '0;
    repeat (SPAWN_FRAMES) frame_tick('0, 1'b0, '1);
    check("spawn_none", 32'(seen_spawn), 0);
    repeat (SPAWN_FRAMES) frame_tick('0, 1'b0, 10'b1111111101);
    seen_spawn = '0;
    repeat (SPAWN_FRAMES) frame_tick('0, 1'b0, 10'b1111011101);
    check("spawn_slot5", 32'(seen_spawn), 32'(10'b0000100000));

    // Scoring and saturation
    frame_tick(10'b0000000101, 1'b0, '1);
    check("score_two", 32'(score), 2);
    repeat (120) frame_tick('1, 1'b0, '1);
    check("score_sat", 32'(score), 999);

    // Hit, invulnerability, blink, return to play
    frame_tick('0, 1'b1, '1);
    check("hit_state", 32'(state), 2);
    check("hit_lives", 32'(lives), 2);
    frame_tick('0, 1'b1, '1);
    check("hit_ignore", 32'(lives), 2);
    repeat (95) frame_tick('0, 1'b0, '1);
    check("hit_back_play", 32'(state), 1);

    // Lose remaining lives, restart through IDLE
    repeat (200) frame_tick('0, 1'b1, '1);
    check("over_state", 32'(state), 3);
    check("over_visible", 32'(ship_visible), 0);
    pulse_start();
    check("over_to_idle", 32'(state), 0);
    pulse_start();
    check("restart_state", 32'(state), 1);
    check("restart_score", 32'(score), 0);

    // Score 98 with two lives, then three shots cross 100
    frame_tick('0, 1'b1, '1);
    repeat (9) frame_tick('1, 1'b0, '1);
    repeat (8) frame_tick(10'b0000000001, 1'b0, '1);
    frame_tick(10'b0000000111, 1'b0, '1);
    check("cross_score", 32'(score), 101);
`ifdef GAME_BONUS_LIFE_EN
    check("cross_lives", 32'(lives), 3);
`else
    check("cross_lives", 32'(lives), 2);
`endif
    check("pre_reset_hit", 32'(state), 2);
    do_reset();
    check("rst_state", 32'(state), 0);
    check("rst_score", 32'(score), 0);

    // Random play
    pulse_start();
    for (int i = 0; i < 4000; i++) begin
      logic [N-1:0] r_shot, r_en;
      r_shot = N'($urandom & $urandom & $urandom);
      r_en   = N'($urandom | $urandom);
      cyc(1'($urandom), ($urandom % 60) == 0, ($urandom % 25) == 0, r_shot, r_en);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
